// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit: multicycle unsigned divider with HI/LO result registers.
// DIVU starts a restoring divide; MFHI/MFLO read the remainder and quotient.
module divu_hilo_unit #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] FUNCT_DIVU = 6'd27,
  parameter logic [5:0] FUNCT_MFHI = 6'd16,
  parameter logic [5:0] FUNCT_MFLO = 6'd18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [5:0]       r_prev_sig;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_r_next;
  logic             w_last;

  // Start fires only on the rising edge of a DIVU code while idle
  assign w_start = (r_state == S_IDLE) &&
                   (signal == FUNCT_DIVU) &&
                   (r_prev_sig != FUNCT_DIVU);

  // One restoring step: shift remainder in the quotient MSB, trial subtract
  assign w_t      = {r_r, r_q[WIDTH-1]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_diff   = w_t[WIDTH-1:0] - r_d;
  assign w_r_next = w_ge ? w_diff : w_t[WIDTH-1:0];
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Edge detector history for the funct code
  always_ff @(posedge clk) begin
    if (reset) r_prev_sig <= 6'd0;
    else       r_prev_sig <= signal;
  end

  // Divide FSM with registered busy/done and HI/LO writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_q     <= dataA;
            r_d     <= dataB;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_r   <= w_r_next;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_hi    <= r_r;
          r_lo    <= r_q;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read mux: only committed HI/LO are visible
  always_comb begin
    dataOut = '0;
    unique case (1'b1)
      (signal == FUNCT_MFHI): dataOut = r_hi;
      (signal == FUNCT_MFLO): dataOut = r_lo;
      default:                dataOut = '0;
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// tb_divu_hilo_unit: directed checks of divu_hilo_unit.
// Start, latency, div-by-zero, reset abort and mid-run interference.
module tb_divu_hilo_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int passed;
  int total;

  divu_hilo_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .signal  (signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi,
                           output logic [31:0] lo);
    signal = 6'd16;
    #1 hi = dataOut;
    signal = 6'd18;
    #1 lo = dataOut;
    signal = 6'd0;
    #1;
  endtask

  task automatic do_div(input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] hi,
                        output logic [31:0] lo,
                        output int lat);
    signal = 6'd0;
    step();
    signal = 6'd27;
    dataA  = a;
    dataB  = b;
    step();
    signal = 6'd0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (done && lat < 0) lat = k;
      if (lat >= 0) break;
    end
    read_hilo(hi, lo);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    signal = 6'd0;
    dataA  = '0;
    dataB  = '0;
    step();
    step();
    reset = 1'b0;
    signal = 6'd16;
    #1;
    total++;
    if (dataOut !== 32'd0)
      $display("FAIL reset_hi got=%0h exp=0", dataOut);
    else passed++;
    signal = 6'd18;
    #1;
    total++;
    if (dataOut !== 32'd0)
      $display("FAIL reset_lo got=%0h exp=0", dataOut);
    else passed++;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_flags got=%b%b exp=00", busy, done);
    else passed++;
    signal = 6'd0;
    step();
  endtask

  task automatic test_basic_hold();
    int first;
    int cnt;
    logic [31:0] hi, lo;
    signal = 6'd27;
    dataA  = 32'd16;
    dataB  = 32'd5;
    step();
    total++;
    if (busy !== 1'b1)
      $display("FAIL hold_busy got=%b exp=1", busy);
    else passed++;
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (done) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (first != 33)
      $display("FAIL hold_latency got=%0d exp=33", first);
    else passed++;
    total++;
    if (cnt != 1)
      $display("FAIL hold_pulses got=%0d exp=1", cnt);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL hold_idle_busy got=%b exp=0", busy);
    else passed++;
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'd1)
      $display("FAIL hold_hi got=%0h exp=1", hi);
    else passed++;
    total++;
    if (lo !== 32'd3)
      $display("FAIL hold_lo got=%0h exp=3", lo);
    else passed++;
    signal = 6'd5;
    #1;
    total++;
    if (dataOut !== 32'd0)
      $display("FAIL other_code got=%0h exp=0", dataOut);
    else passed++;
    signal = 6'd0;
  endtask

  task automatic check_div(input string nm,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [31:0] ehi,
                           input logic [31:0] elo);
    logic [31:0] hi, lo;
    int lat;
    do_div(a, b, hi, lo, lat);
    total++;
    if (lat != 33)
      $display("FAIL %s_lat got=%0d exp=33", nm, lat);
    else passed++;
    total++;
    if (hi !== ehi)
      $display("FAIL %s_hi got=%0h exp=%0h", nm, hi, ehi);
    else passed++;
    total++;
    if (lo !== elo)
      $display("FAIL %s_lo got=%0h exp=%0h", nm, lo, elo);
    else passed++;
  endtask

  task automatic test_values();
    check_div("max", 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF);
    check_div("small", 32'd7, 32'd9, 32'd7, 32'd0);
    check_div("div0", 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    signal = 6'd0;
    step();
    signal = 6'd27;
    dataA  = 32'd16;
    dataB  = 32'd5;
    step();
    for (int k = 0; k < 10; k++) step();
    signal = 6'd0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rmid_flags got=%b%b exp=00", busy, done);
    else passed++;
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL rmid_clear got=%0h/%0h exp=0/0", hi, lo);
    else passed++;
    check_div("rmid_redo", 32'd16, 32'd5, 32'd1, 32'd3);
  endtask

  task automatic test_mid_run();
    logic [31:0] hi, lo;
    int lat;
    signal = 6'd0;
    step();
    signal = 6'd27;
    dataA  = 32'd50;
    dataB  = 32'd7;
    step();
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      dataA = $urandom;
      dataB = $urandom;
      if (k == 5) begin
        signal = 6'd18;
        #1;
        total++;
        if (dataOut !== 32'd3)
          $display("FAIL mid_mflo got=%0h exp=3", dataOut);
        else passed++;
      end else if (k == 6) begin
        signal = 6'd16;
        #1;
        total++;
        if (dataOut !== 32'd1)
          $display("FAIL mid_mfhi got=%0h exp=1", dataOut);
        else passed++;
      end else if (k < 30) begin
        signal = (k % 2 == 0) ? 6'd27 : 6'd0;
      end else begin
        signal = 6'd0;
      end
      step();
      if (done && lat < 0) lat = k;
      if (lat >= 0) break;
    end
    total++;
    if (lat != 33)
      $display("FAIL mid_lat got=%0d exp=33", lat);
    else passed++;
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'd1)
      $display("FAIL mid_hi got=%0h exp=1", hi);
    else passed++;
    total++;
    if (lo !== 32'd7)
      $display("FAIL mid_lo got=%0h exp=7", lo);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic_hold();
    test_values();
    test_reset_mid();
    test_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
